// File: rtl/div_radix2.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU, producing {remainder, quotient}.
// A fixed 32-iteration BUSY phase follows each accepted request; divide-by-zero short-circuits to DONE.
module div_radix2 #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               valid_i,
  input  logic               signed_i,
  output logic               stall_o,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] dividend, divisor, rem, quot;
  logic [CW-1:0]    count;
  logic             sign_q, sign_r;

  logic             start, div_zero;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   trial, diff;
  logic             fits;
  logic [WIDTH-1:0] rem_nxt, quot_nxt, q_fix, r_fix;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    start    = valid_i & ~flush_i;
    div_zero = (b_i == '0);
    mag_a    = (signed_i & a_i[WIDTH-1]) ? -a_i : a_i;
    mag_b    = (signed_i & b_i[WIDTH-1]) ? -b_i : b_i;

    // The shifted remainder needs one extra bit: it can reach 2*divisor-1.
    trial    = {rem, dividend[WIDTH-1]};
    diff     = trial - {1'b0, divisor};
    fits     = (trial >= {1'b0, divisor});
    rem_nxt  = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    quot_nxt = {quot[WIDTH-2:0], fits};
    q_fix    = sign_q ? -quot_nxt : quot_nxt;
    r_fix    = sign_r ? -rem_nxt  : rem_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = div_zero ? DONE : BUSY;
      BUSY:    if (count == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush_i) state_nxt = IDLE;
  end

  assign stall_o = valid_i & (state != DONE) & ~flush_i & ~rst;

  // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      result_o <= '0;
      ready_o  <= 1'b0;
      count    <= '0;
    end else begin
      state   <= state_nxt;
      ready_o <= (state_nxt == DONE);
      case (state)
        IDLE: if (start) begin
          dividend <= mag_a;
          divisor  <= mag_b;
          rem      <= '0;
          quot     <= '0;
          count    <= '0;
          sign_q   <= signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
          sign_r   <= signed_i & a_i[WIDTH-1];
          if (div_zero) result_o <= {a_i, {WIDTH{1'b1}}};
        end
        BUSY: if (!flush_i) begin
          dividend <= dividend << 1;
          rem      <= rem_nxt;
          quot     <= quot_nxt;
          count    <= count + CW'(1);
          if (count == LAST) result_o <= {r_fix, q_fix};
        end
        default: ;
      endcase
    end
  end

  // NOTE: the datapath registers (dividend, divisor, rem, quot, signs) are deliberately left out of reset;
  // they are always loaded on a start before being read.

endmodule

// File: tb/tb_div_radix2.sv
// Self-checking bench for div_radix2: directed corner cases plus randomized operations
// compared against an arithmetic reference model.
module tb_div_radix2;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst, flush_i, valid_i, signed_i;
  logic [W-1:0]   a_i, b_i;
  logic           stall_o, ready_o;
  logic [2*W-1:0] result_o;

  int checks = 0;
  int failures = 0;
  logic [63:0] last_exp = '0;

  div_radix2 #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush_i  (flush_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .valid_i  (valid_i),
    .signed_i (signed_i),
    .stall_o  (stall_o),
    .result_o (result_o),
    .ready_o  (ready_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Reference: divide magnitudes with plain arithmetic, then apply the sign rules.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    logic [31:0] ma, mb, q, r;
    if (b == 0) return {a, 32'hFFFF_FFFF};
    ma = (sgn && a[31]) ? -a : a;
    mb = (sgn && b[31]) ? -b : b;
    q  = ma / mb;
    r  = ma % mb;
    if (sgn && (a[31] ^ b[31])) q = -q;
    if (sgn && a[31]) r = -r;
    return {r, q};
  endfunction

  // Issues one request; inputs are scrambled while busy, valid optionally dropped at cycle drop_at.
  task automatic divide(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sgn, input bit hold, input int drop_at);
    logic [63:0] exp;
    int lat, c, stall_err;
    exp = ref_div(a, b, sgn);
    lat = (b == 0) ? 1 : 33;
    stall_err = 0;
    @(negedge clk);
    a_i = a; b_i = b; signed_i = sgn; valid_i = 1'b1;
    #1;
    c = 0;
    while (c <= 40) begin
      if (ready_o) break;
      if (stall_o !== valid_i) stall_err++;
      if (c >= 1) begin
        a_i = $urandom; b_i = $urandom; signed_i = 1'($urandom_range(0, 1));
        if (c == drop_at) valid_i = 1'b0;
      end
      @(negedge clk);
      c++;
    end
    check({tag, " latency"}, 64'(c), 64'(lat));
    check({tag, " stall_busy"}, 64'(stall_err), 64'd0);
    check({tag, " stall_done"}, 64'(stall_o), 64'd0);
    check({tag, " result"}, result_o, exp);
    last_exp = exp;
    if (!hold) begin
      valid_i = 1'b0;
      @(negedge clk);
      check({tag, " ready_pulse"}, 64'(ready_o), 64'd0);
      check({tag, " result_hold"}, result_o, exp);
    end
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    int pulses;
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (ready_o) pulses++;
    end
    check({tag, " no_ready"}, 64'(pulses), 64'd0);
    check({tag, " result_kept"}, result_o, last_exp);
  endtask

  initial begin
    logic [31:0] ra, rb;
    rst = 1'b1; flush_i = 1'b0; valid_i = 1'b1; signed_i = 1'b0; a_i = 32'd3; b_i = 32'd1;
    repeat (2) @(negedge clk);
    check("reset result", result_o, 64'd0);
    check("reset ready", 64'(ready_o), 64'd0);
    check("reset stall", 64'(stall_o), 64'd0);
    valid_i = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("idle stall", 64'(stall_o), 64'd0);

    divide("divu_100_7", 32'd100, 32'd7, 1'b0, 1'b0, 0);
    check("divu_100_7 value", result_o, 64'h00000002_0000000E);
    divide("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 0);
    check("div_m7_2 value", result_o, 64'hFFFFFFFF_FFFFFFFD);
    divide("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, 0);
    check("div_7_m2 value", result_o, 64'h00000001_FFFFFFFD);
    divide("div_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 0);
    check("div_min_m1 value", result_o, 64'h00000000_80000000);
    divide("divu_min_max", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
    divide("divu_max_min", 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 0);
    check("divu_max_min value", result_o, 64'h7FFFFFFF_00000001);
    divide("divu_5_0", 32'd5, 32'd0, 1'b0, 1'b0, 0);
    check("divu_5_0 value", result_o, 64'h00000005_FFFFFFFF);
    divide("div_big_rem", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0, 0);

    // Flush at cycle 10 of an operation.
    @(negedge clk);
    a_i = 32'd100; b_i = 32'd7; signed_i = 1'b0; valid_i = 1'b1;
    repeat (10) @(negedge clk);
    flush_i = 1'b1;
    #1;
    check("flush stall", 64'(stall_o), 64'd0);
    @(negedge clk);
    flush_i = 1'b0; valid_i = 1'b0;
    expect_quiet("flush", 40);
    divide("post_flush_9_4", 32'd9, 32'd4, 1'b0, 1'b0, 0);
    check("post_flush value", result_o, 64'h00000001_00000002);

    // Flush together with a request in IDLE must not start anything.
    @(negedge clk);
    a_i = 32'd5; b_i = 32'd0; valid_i = 1'b1; flush_i = 1'b1;
    #1;
    check("flush_valid stall", 64'(stall_o), 64'd0);
    @(negedge clk);
    valid_i = 1'b0; flush_i = 1'b0;
    expect_quiet("flush_valid", 4);

    // Back-to-back with valid held across DONE.
    divide("b2b_first", 32'd100, 32'd7, 1'b0, 1'b1, 0);
    divide("b2b_second", 32'hFFFF_FFF7, 32'd4, 1'b1, 1'b0, 0);
    check("b2b_second value", result_o, 64'hFFFFFFFF_FFFFFFFE);

    // valid dropping mid-BUSY still completes.
    divide("drop_valid", 32'd1000, 32'd33, 1'b0, 1'b0, 6);

    // Reset in the middle of BUSY.
    @(negedge clk);
    a_i = 32'd123; b_i = 32'd5; signed_i = 1'b0; valid_i = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid stall", 64'(stall_o), 64'd0);
    @(negedge clk);
    check("rst_mid result", result_o, 64'd0);
    check("rst_mid ready", 64'(ready_o), 64'd0);
    rst = 1'b0; valid_i = 1'b0;
    last_exp = '0;
    expect_quiet("rst_mid", 40);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 1) == 1) ra = ra >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) rb = rb >> $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) rb = '0;
      divide($sformatf("rand%0d", i), ra, rb, 1'($urandom_range(0, 1)), 1'b0,
             (rb != 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(2, 30)) : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
